// File: rtl/pipe_reg_elastic.sv
// Elastic valid/ready register chain with flush and occupancy count.
// Bubbles collapse under backpressure; only blocked stages stall.
module pipe_reg_elastic #(
  parameter int                 DATA_W     = 64,
  parameter int                 DEPTH      = 2,
  parameter logic [DATA_W-1:0]  PRESET_VAL = '0,
  parameter int                 CNT_W      = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  occupancy
);

  logic [DEPTH-1:0]  v;
  logic [DATA_W-1:0] d [DEPTH];
  logic [CNT_W-1:0]  cnt;

  logic [DEPTH:0]    rdy;
  logic [DEPTH-1:0]  src_v;
  logic [DATA_W-1:0] src_d [DEPTH];
  logic              in_fire;
  logic              out_fire;

  // A stage can take a word if it is empty or its successor moves.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH-1; i >= 0; i--) begin
      rdy[i] = ~v[i] | rdy[i+1];
    end
  end

  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data  = d[DEPTH-1];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = cnt;

  always_ff @(posedge clk) begin
    if (srst) begin
      v   <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= PRESET_VAL;
      end
    end else if (flush) begin
      v   <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v[i] <= src_v[i];
          if (src_v[i]) begin
            d[i] <= src_d[i];
          end
        end
      end
      cnt <= cnt + CNT_W'(in_fire) - CNT_W'(out_fire);
    end
  end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed and soak bench for pipe_reg_elastic (DATA_W=8, DEPTH=3).
// Inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
module tb_pipe_reg_elastic;

  logic       clk = 1'b0;
  logic       srst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] occupancy;

  int checks = 0;
  int failures = 0;

  pipe_reg_elastic #(
    .DATA_W    (8),
    .DEPTH     (3),
    .PRESET_VAL(8'hA5)
  ) dut (
    .clk      (clk),
    .srst     (srst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .flush    (flush),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (2) tick();
    srst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL rst_out_data got %h exp a5", out_data); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    tick();
  endtask

  task automatic test_streaming();
    logic       ev;
    logic [1:0] eo;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 4);
      in_data  = 8'(c + 1);
      #1;
      ev = (c >= 3) && (c <= 6);
      eo = (c <= 3) ? 2'(c) : 2'(7 - c);
      checks++; if (out_valid !== ev) begin failures++; $display("FAIL stream_valid c=%0d got %b exp %b", c, out_valid, ev); end
      if (ev) begin
        checks++; if (out_data !== 8'(c - 2)) begin failures++; $display("FAIL stream_data c=%0d got %h exp %h", c, out_data, 8'(c - 2)); end
      end
      checks++; if (occupancy !== eo) begin failures++; $display("FAIL stream_occ c=%0d got %0d exp %0d", c, occupancy, eo); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready c=%0d got %b exp 1", c, in_ready); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = 8'(8'h10 + c);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_fill_ready c=%0d got %b exp 1", c, in_ready); end
      tick();
    end
    in_data = 8'h13;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    checks++; if (occupancy !== 2'd3) begin failures++; $display("FAIL bp_full_occ got %0d exp 3", occupancy); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h10) begin failures++; $display("FAIL bp_full_out got %b/%h exp 1/10", out_valid, out_data); end
    tick();
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_pass_ready got %b exp 1", in_ready); end
    checks++; if (out_data !== 8'h10) begin failures++; $display("FAIL bp_pass_data got %h exp 10", out_data); end
    tick();
    out_ready = 1'b0;
    in_data   = 8'h14;
    #1;
    checks++; if (occupancy !== 2'd3) begin failures++; $display("FAIL bp_after_occ got %0d exp 3", occupancy); end
    checks++; if (out_data !== 8'h11) begin failures++; $display("FAIL bp_after_data got %h exp 11", out_data); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_after_ready got %b exp 0", in_ready); end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'(8'h11 + k)) begin failures++; $display("FAIL bp_drain k=%0d got %b/%h exp 1/%h", k, out_valid, out_data, 8'(8'h11 + k)); end
      tick();
    end
    #1;
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL bp_drained_occ got %0d exp 0", occupancy); end
    tick();
  endtask

  task automatic test_bubble_collapse();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h21;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 8'h22;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bub_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL bub_occ got %0d exp 2", occupancy); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h21) begin failures++; $display("FAIL bub_head got %b/%h exp 1/21", out_valid, out_data); end
    out_ready = 1'b1;
    tick();
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin failures++; $display("FAIL bub_second got %b/%h exp 1/22", out_valid, out_data); end
    tick();
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL bub_empty got %b/%0d exp 0/0", out_valid, occupancy); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = 8'(8'h40 + c);
      tick();
    end
    flush     = 1'b1;
    in_data   = 8'h33;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fl_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fl_out_valid got %b exp 0", out_valid); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL fl_after got %0d/%b exp 0/0", occupancy, out_valid); end
    checks++; if (out_data !== 8'h40) begin failures++; $display("FAIL fl_data_held got %h exp 40", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fl_reaccept got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fl_latency k=%0d got %b exp 0", k, out_valid); end
      tick();
    end
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h33) begin failures++; $display("FAIL fl_emerge got %b/%h exp 1/33", out_valid, out_data); end
    tick();
  endtask

  task automatic test_reset_flush_soak();
    logic [7:0] q[$];
    logic       exp_rdy;
    logic [7:0] w;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = 8'(8'h50 + c);
      tick();
    end
    in_valid = 1'b0;
    srst     = 1'b1;
    flush    = 1'b1;
    tick();
    srst  = 1'b0;
    flush = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL rf_state got %b/%0d exp 0/0", out_valid, occupancy); end
    checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL rf_data got %h exp a5", out_data); end
    tick();
    for (int n = 0; n < 10000; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = (q.size() < 3) || out_ready;
      checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL soak_ready n=%0d got %b exp %b", n, in_ready, exp_rdy); end
      checks++; if (occupancy !== 2'(q.size())) begin failures++; $display("FAIL soak_occ n=%0d got %0d exp %0d", n, occupancy, q.size()); end
      if (out_valid === 1'b1) begin
        w = (q.size() > 0) ? q[0] : 8'hxx;
        checks++; if (q.size() == 0 || out_data !== w) begin failures++; $display("FAIL soak_data n=%0d got %h exp %h", n, out_data, w); end
        if (out_ready && q.size() > 0) void'(q.pop_front());
      end
      if (in_valid && exp_rdy) q.push_back(in_data);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (out_valid === 1'b1) begin
        w = (q.size() > 0) ? q[0] : 8'hxx;
        checks++; if (q.size() == 0 || out_data !== w) begin failures++; $display("FAIL drain_data k=%0d got %h exp %h", k, out_data, w); end
        if (q.size() > 0) void'(q.pop_front());
      end
      tick();
    end
    #1;
    checks++; if (q.size() != 0 || occupancy !== 2'd0) begin failures++; $display("FAIL drain_end left=%0d occ=%0d exp 0/0", q.size(), occupancy); end
  endtask

  initial begin
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_flush();
    test_reset_flush_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
